// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and helpers for the multi-channel PWM
// Purpose: counting-mode and direction encodings, duty slice width helper.
// Ports: none (package).
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Duty is one bit wider than the counter so that 100% is reachable
  // even when the period register is at its maximum value.
  function automatic int duty_width(input int cnt_bits);
    return cnt_bits + 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - clock prescaler producing the counter advance tick
// Purpose: counts 0..prescale and ticks on the terminal value, then wraps.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear (holds the count at 0, suppresses tick)
//   prescale    live divide value; tick every prescale+1 clocks
//   tick        combinational advance strobe
module pwm_prescaler #(
  parameter int PRESC_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [PRESC_BITS-1:0] prescale,
  output logic                  tick
);

  logic [PRESC_BITS-1:0] psc;

  assign tick = !clr && (psc == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (clr || tick) begin
      psc <= '0;
    end else begin
      psc <= psc + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with shared period counter
// Purpose: shared prescaler and edge/center-aligned period counter driving
//   NUM_CH duty comparators; period/mode/duty load only at period boundaries.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   en            run enable (0 holds counter and tracks inputs)
//   mode          0 edge-aligned, 1 center-aligned
//   prescale      counter advances every prescale+1 clocks
//   period        terminal count P
//   duty          per-channel duty, CNT_BITS+1 bits per channel
//   update_req    request a load at the next boundary
//   pwm_out       registered PWM outputs
//   period_start  pulse in the first cycle of each period
//   update_done   pulse in the first cycle after a boundary load
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_BITS   = 8,
  parameter int PRESC_BITS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                mode,
  input  logic [PRESC_BITS-1:0]               prescale,
  input  logic [CNT_BITS-1:0]                 period,
  input  logic [NUM_CH*duty_width(CNT_BITS)-1:0] duty,
  input  logic                                update_req,
  output logic [NUM_CH-1:0]                   pwm_out,
  output logic                                period_start,
  output logic                                update_done
);

  localparam int DW = duty_width(CNT_BITS);

  logic                tick;
  logic [CNT_BITS-1:0] cnt, cnt_nxt, period_a;
  logic                mode_a, dir, dir_nxt, pending;
  logic                terminal, load;

  pwm_prescaler #(.PRESC_BITS(PRESC_BITS)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!en),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next counter value if the current clock is a tick. P=0 falls into the
  // edge branch in both modes so the counter simply holds at 0.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (mode_a == PWM_EDGE || period_a == '0) begin
      cnt_nxt = (cnt >= period_a) ? '0 : cnt + 1'b1;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt >= period_a) begin
        // Turning point; with P=1 the down leg is empty and we land on 0.
        cnt_nxt = period_a - 1'b1;
        dir_nxt = (period_a == 1) ? DIR_UP : DIR_DOWN;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      cnt_nxt = cnt - 1'b1;
      dir_nxt = (cnt == 1) ? DIR_UP : DIR_DOWN;
    end
  end

  assign terminal = tick && (cnt_nxt == '0);
  assign load     = terminal && (pending || update_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      pending      <= 1'b0;
      period_a     <= '0;
      mode_a       <= PWM_EDGE;
      period_start <= 1'b0;
      update_done  <= 1'b0;
    end else if (!en) begin
      // Stopped: active registers track the inputs so a restart uses them.
      cnt          <= '0;
      dir          <= DIR_UP;
      pending      <= 1'b0;
      period_a     <= period;
      mode_a       <= mode;
      period_start <= 1'b0;
      update_done  <= 1'b0;
    end else begin
      period_start <= terminal;
      update_done  <= load;
      if (tick) begin
        cnt <= cnt_nxt;
        dir <= dir_nxt;
      end
      if (load) begin
        period_a <= period;
        mode_a   <= mode;
        dir      <= DIR_UP;
        pending  <= 1'b0;
      end else if (update_req) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DW-1:0] duty_a;
    logic          out_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_a <= '0;
        out_q  <= 1'b0;
      end else if (!en) begin
        duty_a <= duty[ch*DW +: DW];
        out_q  <= 1'b0;
      end else begin
        // Compare uses the current period's duty; a load on this edge
        // only affects the comparison made for the new period's cnt=0.
        out_q <= ({1'b0, cnt} < duty_a);
        if (load) begin
          duty_a <= duty[ch*DW +: DW];
        end
      end
    end

    assign pwm_out[ch] = out_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - self-checking bench for pwm_multi_channel
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int CNT_BITS   = 8;
  localparam int PRESC_BITS = 4;
  localparam int DW         = CNT_BITS + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic                   mode = PWM_EDGE;
  logic [PRESC_BITS-1:0]  prescale = '0;
  logic [CNT_BITS-1:0]    period = '0;
  logic [NUM_CH*DW-1:0]   duty = '0;
  logic                   update_req = 1'b0;
  logic [NUM_CH-1:0]      pwm_out;
  logic                   period_start;
  logic                   update_done;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .NUM_CH(NUM_CH), .CNT_BITS(CNT_BITS), .PRESC_BITS(PRESC_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .prescale(prescale),
    .period(period), .duty(duty), .update_req(update_req),
    .pwm_out(pwm_out), .period_start(period_start), .update_done(update_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: position within the period is a tick index k; the
  // counter value is derived from k by the period shape.
  int              m_psc, m_k, m_pa;
  bit              m_ma, m_pend;
  int              m_da[NUM_CH];
  bit [NUM_CH-1:0] e_pwm;
  bit              e_ps, e_ud;
  int              hi0, ps_cnt, ud_cnt;

  function automatic int per_len();
    if (m_ma == PWM_EDGE) return m_pa + 1;
    return (m_pa == 0) ? 1 : 2 * m_pa;
  endfunction

  function automatic int cnt_at(input int k);
    if (m_ma == PWM_EDGE || k <= m_pa) return k;
    return 2 * m_pa - k;
  endfunction

  function automatic int duty_in(input int ch);
    return int'(duty[ch*DW +: DW]);
  endfunction

  task automatic set_duty(input int ch, input int v);
    duty[ch*DW +: DW] = DW'(v);
  endtask

  task automatic model_reset();
    m_psc = 0; m_k = 0; m_pa = 0; m_ma = 0; m_pend = 0;
    for (int ch = 0; ch < NUM_CH; ch++) m_da[ch] = 0;
    e_pwm = '0; e_ps = 0; e_ud = 0;
  endtask

  task automatic model_load();
    m_pa = int'(period);
    m_ma = mode;
    for (int ch = 0; ch < NUM_CH; ch++) m_da[ch] = duty_in(ch);
  endtask

  task automatic model_edge();
    bit t, term, ld;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!en) begin
      model_load();
      m_psc = 0; m_k = 0; m_pend = 0;
      e_pwm = '0; e_ps = 0; e_ud = 0;
      return;
    end
    for (int ch = 0; ch < NUM_CH; ch++) e_pwm[ch] = (cnt_at(m_k) < m_da[ch]);
    t = (m_psc == int'(prescale));
    m_psc = t ? 0 : (m_psc + 1) % (1 << PRESC_BITS);
    term = 0;
    if (t) begin
      m_k  = (m_k + 1) % per_len();
      term = (m_k == 0);
    end
    ld = term && (m_pend || update_req);
    if (ld) begin
      model_load();
      m_k = 0;
      m_pend = 0;
    end else if (update_req) begin
      m_pend = 1;
    end
    e_ps = term;
    e_ud = ld;
  endtask

  task automatic compare_all();
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("pwm_out[%0d]", ch), int'(pwm_out[ch]), int'(e_pwm[ch]));
    check("period_start", int'(period_start), int'(e_ps));
    check("update_done", int'(update_done), int'(e_ud));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    hi0    += int'(pwm_out[0]);
    ps_cnt += int'(period_start);
    ud_cnt += int'(update_done);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_update();
    update_req = 1'b1;
    step();
    update_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    model_reset();
    @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset update_done", int'(update_done), 0);
    rst_n = 1'b1;

    // Edge mode, P=9, duty0=3; active values captured while stopped.
    mode = PWM_EDGE; prescale = 0; period = 9;
    set_duty(0, 3); set_duty(1, 5); set_duty(2, 0); set_duty(3, 10);
    run(2);
    en = 1'b1;
    step();
    check("first high after en", int'(pwm_out[0]), 1);
    hi0 = 0; ps_cnt = 0;
    run(20);
    check("edge duty3 highs/20", hi0, 6);
    check("edge period_start/20", ps_cnt, 2);

    // Duty extremes.
    set_duty(0, 0); set_duty(1, 10); set_duty(2, 256); set_duty(3, 9);
    pulse_update();
    run(30);

    // Center mode P=4 duty 2.
    mode = PWM_CENTER; period = 4;
    set_duty(0, 2); set_duty(1, 0); set_duty(2, 5); set_duty(3, 4);
    pulse_update();
    run(16);
    hi0 = 0; ps_cnt = 0;
    run(16);
    check("center duty2 highs/16", hi0, 6);
    check("center period_start/16", ps_cnt, 2);

    // Prescale 3, edge P=9.
    mode = PWM_EDGE; prescale = 3; period = 9; set_duty(0, 3);
    pulse_update();
    run(50);
    ps_cnt = 0;
    run(80);
    check("presc3 period_start/80", ps_cnt, 2);

    // Mid-period update 3->7 with a repeated request.
    prescale = 0;
    run(45);
    guard = 0;
    while (!period_start && guard < 50) begin
      step();
      guard++;
    end
    check("wait period_start", int'(period_start), 1);
    run(2);
    set_duty(0, 7);
    ud_cnt = 0;
    pulse_update();
    run(2);
    pulse_update();
    run(15);
    check("single update_done", ud_cnt, 1);
    hi0 = 0;
    run(20);
    check("duty7 highs/20", hi0, 14);

    // Randomized configurations, requests, enable drops and live changes.
    for (int it = 0; it < 25; it++) begin
      int n;
      mode = $urandom_range(0, 1);
      prescale = PRESC_BITS'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        period = CNT_BITS'($urandom_range(200, 255));
        prescale = 0;
      end else begin
        period = CNT_BITS'($urandom_range(0, 20));
      end
      for (int ch = 0; ch < NUM_CH; ch++)
        set_duty(ch, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 511)
                                                  : $urandom_range(0, int'(period) + 2));
      n = $urandom_range(40, 120);
      for (int c = 0; c < n; c++) begin
        update_req = ($urandom_range(0, 15) == 0);
        en = ($urandom_range(0, 40) != 0);
        if ($urandom_range(0, 20) == 0)
          set_duty($urandom_range(0, NUM_CH - 1), $urandom_range(0, 300));
        step();
      end
      update_req = 1'b0;
      en = 1'b1;
    end

    // Asynchronous reset mid-period.
    mode = PWM_EDGE; prescale = 0; period = 9;
    for (int ch = 0; ch < NUM_CH; ch++) set_duty(ch, 6);
    pulse_update();
    run(14);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset period_start", int'(period_start), 0);
    check("async reset update_done", int'(update_done), 0);
    step();
    rst_n = 1'b1;
    hi0 = 0;
    run(15);
    check("post reset stays low", hi0, 0);
    pulse_update();
    run(15);
    en = 1'b0;
    step();
    check("en drop pwm_out", int'(pwm_out), 0);
    en = 1'b1;
    run(25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator, successor to the single-channel 8-bit PWM top. A shared prescaler and period counter drive NUM_CH independent duty comparators. The block adds programmable period, edge- or center-aligned counting, and boundary-synchronous (glitch-free) duty/period updates. It sits between the control-register file and the pad drivers.

## Interface
- NUM_CH, 4: number of PWM channels.
- CNT_BITS, 8: period counter width.
- PRESC_BITS, 4: prescaler width.

- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- mode  in  1  0 = edge-aligned, 1 = center-aligned.
- prescale  in  PRESC_BITS  counter advances every prescale+1 clocks.
- period  in  CNT_BITS  terminal count P.
- duty  in  NUM_CH*(CNT_BITS+1)  per-channel duty, channel ch at bits [ch*(CNT_BITS+1) +: CNT_BITS+1].
- update_req  in  1  one-cycle pulse requesting a load at the next boundary.
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse at the start of each period.
- update_done  out  1  one-cycle pulse when the active registers were loaded.

## Operation
- Active registers: period_a, mode_a, duty_a[ch].
  - Counter and comparators use only the active registers, never the inputs directly.
- Prescaler: counts 0..prescale and emits a tick when it equals prescale, then wraps to 0.
  - prescale=0 gives a tick every clock.
  - prescale is read live, not shadowed.
- Counter advances only on a tick.
  - Edge mode: 0,1,..,P, then 0. Period is P+1 ticks.
  - Center mode: dir flag. Up: 0..P, then dir=down. Down: P-1..1, then 0 with dir=up. Period is 2P ticks.
  - P=0 in either mode: counter holds at 0 and every tick is terminal.
- Terminal tick: a tick whose next counter value is 0.
- Boundary load on a terminal tick with pending=1:
  - active registers ← current inputs (period, mode, duty).
  - dir ← up; pending ← 0.
  - Values are sampled at the boundary, not at request time.
- update_req sets pending.
  - If update_req coincides with a terminal tick, the load happens on that tick.
- Compare: raw[ch] = (cnt < duty_a[ch]).
  - duty=0 gives 0%.
  - duty ≥ P+1 (edge) or duty ≥ P+1 (center) gives 100%.
  - Duty is one bit wider than the counter so 100% is reachable at P = 2^CNT_BITS−1.
- en=0:
  - prescaler, cnt and dir (=up) held at reset values.
  - active registers continuously follow the inputs.
  - pending cleared; all outputs 0.
- en 0→1: counting starts from cnt=0 with the active values captured in the last en=0 cycle.

## Timing
- Reset (asynchronous, immediate): pwm_out=0, period_start=0, update_done=0, cnt=0, prescaler=0, dir=up, pending=0, all active registers 0.
- pwm_out[ch] is registered and lags the counter value by exactly 1 clock.
- period_start and update_done are registered.
  - Both assert in the single clock cycle immediately after the terminal tick, coincident with the first cycle of cnt=0.
- update_done never asserts without a prior update_req.
- Between boundaries, the duty seen by the comparators is constant. No runt or extra pulses on any update.
- A second update_req before the boundary is absorbed: one load, one update_done.

## Structure
- Package pwm_pkg:
  - mode constants PWM_EDGE=1'b0, PWM_CENTER=1'b1.
  - helper function for the duty slice width (CNT_BITS+1).
- Sub-module pwm_prescaler:
  - ports clk, rst_n, clr, prescale, tick.
  - clr is driven by !en.
- Counter, shadow logic and per-channel compare live in the top, with the channels generated.

## Test plan
- Edge mode, prescale=0, P=9, duty0=3, en=1:
  - pwm_out[0] high 3 of every 10 clocks.
  - period_start every 10 clocks.
  - first high 1 clock after en rises.
- Duty extremes, P=9:
  - duty=0 keeps the output constant 0.
  - duty=10 and duty=256 keep the output constant 1, with no glitch across the wrap.
- Center mode, P=4, duty=2, prescale=0:
  - cnt sequence 0,1,2,3,4,3,2,1; period 8 clocks.
  - output high for cnt 0,1 and down-count 1: 3 of 8 clocks, symmetric about cnt=4.
- prescale=3, edge, P=9:
  - each cnt value held 4 clocks.
  - period_start every 40 clocks.
- Update, duty 3→7 with update_req mid-period:
  - old duty is kept until the boundary.
  - update_done and period_start pulse together.
  - the next period is high for 7.
  - two requests before the boundary produce a single update_done.
- rst_n low mid-period:
  - all outputs 0 immediately.
  - after release with en=1, cnt restarts at 0 with active values 0, so the output stays low until an update.
  - en dropped for 1 clock gives outputs 0 on the next clock and a restart from cnt=0.
